// File: rtl/ddr2_odt_ctrl.sv
// ddr2_odt_ctrl
// Controller-side On-Die-Termination generator for the DDR2 command pads.
// It registers the next command onto the pads and drives odt_pad in
// lock-step, so that ODT rises ON_DLY pad cycles after a WRITE, stays high
// for HOLD cycles (extended by further WRITEs) and drops on any READ.
//
// Parameters:
//   AL  additive latency (0..4)
//   CL  CAS latency (3..6)
//   BL  burst length (4 or 8)
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   cmd_valid                          cmd_* hold a command for the pads
//   cmd_cke, cmd_csbar, cmd_rasbar,
//   cmd_casbar, cmd_webar              command fields
//   odt_en                             Rtt enabled in EMR
//   cke_pad, csbar_pad, rasbar_pad,
//   casbar_pad, webar_pad              registered command pads
//   odt_pad                            registered ODT pad
//   odt_busy                           an ODT window is pending or active
//   odt_conflict                       sticky: READ hit a live window

module ddr2_odt_ctrl #(
    parameter int AL = 0,
    parameter int CL = 4,
    parameter int BL = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cmd_valid,
    input  logic cmd_cke,
    input  logic cmd_csbar,
    input  logic cmd_rasbar,
    input  logic cmd_casbar,
    input  logic cmd_webar,
    input  logic odt_en,
    output logic cke_pad,
    output logic csbar_pad,
    output logic rasbar_pad,
    output logic casbar_pad,
    output logic webar_pad,
    output logic odt_pad,
    output logic odt_busy,
    output logic odt_conflict
);

    // Reject unsupported latency/burst settings at elaboration time.
    if (AL < 0 || AL > 4) begin : g_bad_al
        $fatal(1, "ddr2_odt_ctrl: AL out of range 0..4");
    end
    if (CL < 3 || CL > 6) begin : g_bad_cl
        $fatal(1, "ddr2_odt_ctrl: CL out of range 3..6");
    end
    if (BL != 4 && BL != 8) begin : g_bad_bl
        $fatal(1, "ddr2_odt_ctrl: BL must be 4 or 8");
    end

    localparam logic [4:0] ON_DLY = 5'(AL + CL - 3);
    localparam logic [4:0] HOLD   = 5'(BL / 2 + 3);
    localparam logic [4:0] OFF_LD = 5'(AL + CL - 3 + BL / 2 + 3);

    typedef enum logic [1:0] {IDLE, DELAY, ON} state_t;

    state_t     state, state_n;
    logic [4:0] cnt_on, cnt_on_n;
    logic [4:0] cnt_off, cnt_off_n;
    logic       conflict_n;

    logic cke_d, cs_d, ras_d, cas_d, we_d;
    logic act_d, write_d, read_d;

    // Values about to be loaded into the pads; a deselect keeps CKE as-is.
    always_comb begin
        cke_d = cke_pad;
        cs_d  = 1'b1;
        ras_d = 1'b1;
        cas_d = 1'b1;
        we_d  = 1'b1;
        if (cmd_valid) begin
            cke_d = cmd_cke;
            cs_d  = cmd_csbar;
            ras_d = cmd_rasbar;
            cas_d = cmd_casbar;
            we_d  = cmd_webar;
        end
    end

    // Decode from the incoming pad values so ODT tracks the pad cycle itself.
    assign act_d   = cke_d & ~cs_d;
    assign write_d = act_d & ras_d & ~cas_d & ~we_d;
    assign read_d  = act_d & ras_d & ~cas_d & we_d;

    // Next-state logic. cnt_off counts down through the whole window so a
    // WRITE arriving during DELAY only pushes the fall; the pending rise keeps
    // counting. READ beats everything, then a disabled Rtt, then WRITE.
    always_comb begin
        state_n    = state;
        cnt_on_n   = cnt_on;
        cnt_off_n  = cnt_off;
        conflict_n = odt_conflict;

        if (state != IDLE && cnt_off != 5'd0) begin
            cnt_off_n = cnt_off - 5'd1;
        end

        case (state)
            DELAY: begin
                if (cnt_on != 5'd0) begin
                    cnt_on_n = cnt_on - 5'd1;
                end
                if (cnt_on <= 5'd1) begin
                    state_n = ON;
                end
            end
            ON: begin
                if (cnt_off <= 5'd1) begin
                    state_n = IDLE;
                end
            end
            default: ;
        endcase

        if (read_d) begin
            state_n   = IDLE;
            cnt_on_n  = 5'd0;
            cnt_off_n = 5'd0;
            if (state != IDLE) begin
                conflict_n = 1'b1;
            end
        end else if (!odt_en) begin
            state_n   = IDLE;
            cnt_on_n  = 5'd0;
            cnt_off_n = 5'd0;
        end else if (write_d) begin
            cnt_off_n = OFF_LD;
            if (state == IDLE) begin
                cnt_on_n = ON_DLY;
                state_n  = (ON_DLY == 5'd0) ? ON : DELAY;
            end else if (state == ON) begin
                state_n = ON;
            end
        end
    end

    // Pad, FSM and flag registers; ODT and busy are registered decodes of
    // the next state so they line up with the command pads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cke_pad      <= 1'b0;
            csbar_pad    <= 1'b1;
            rasbar_pad   <= 1'b1;
            casbar_pad   <= 1'b1;
            webar_pad    <= 1'b1;
            odt_pad      <= 1'b0;
            odt_busy     <= 1'b0;
            odt_conflict <= 1'b0;
            state        <= IDLE;
            cnt_on       <= 5'd0;
            cnt_off      <= 5'd0;
        end else begin
            cke_pad      <= cke_d;
            csbar_pad    <= cs_d;
            rasbar_pad   <= ras_d;
            casbar_pad   <= cas_d;
            webar_pad    <= we_d;
            odt_pad      <= (state_n == ON);
            odt_busy     <= (state_n != IDLE);
            odt_conflict <= conflict_n;
            state        <= state_n;
            cnt_on       <= cnt_on_n;
            cnt_off      <= cnt_off_n;
        end
    end

    logic unused_hold;
    assign unused_hold = ^HOLD;

endmodule

// File: tb/tb_ddr2_odt_ctrl.sv
// tb_ddr2_odt_ctrl
// Drives three ddr2_odt_ctrl instances (defaults, AL4/CL6/BL8, AL0/CL3)
// from one command stream and compares every pad against a window model
// that tracks absolute pad-cycle numbers for ODT rise and fall.

module tb_ddr2_odt_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic cmd_valid, cmd_cke, cmd_csbar, cmd_rasbar, cmd_casbar, cmd_webar;
    logic odt_en;
    logic [2:0] cke_p, cs_p, ras_p, cas_p, we_p, odt_p, busy_p, conf_p;

    always #5 clk = ~clk;

    ddr2_odt_ctrl u_d0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_cke(cmd_cke),
        .cmd_csbar(cmd_csbar), .cmd_rasbar(cmd_rasbar), .cmd_casbar(cmd_casbar),
        .cmd_webar(cmd_webar), .odt_en(odt_en), .cke_pad(cke_p[0]),
        .csbar_pad(cs_p[0]), .rasbar_pad(ras_p[0]), .casbar_pad(cas_p[0]),
        .webar_pad(we_p[0]), .odt_pad(odt_p[0]), .odt_busy(busy_p[0]),
        .odt_conflict(conf_p[0])
    );

    ddr2_odt_ctrl #(.AL(4), .CL(6), .BL(8)) u_d1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_cke(cmd_cke),
        .cmd_csbar(cmd_csbar), .cmd_rasbar(cmd_rasbar), .cmd_casbar(cmd_casbar),
        .cmd_webar(cmd_webar), .odt_en(odt_en), .cke_pad(cke_p[1]),
        .csbar_pad(cs_p[1]), .rasbar_pad(ras_p[1]), .casbar_pad(cas_p[1]),
        .webar_pad(we_p[1]), .odt_pad(odt_p[1]), .odt_busy(busy_p[1]),
        .odt_conflict(conf_p[1])
    );

    ddr2_odt_ctrl #(.AL(0), .CL(3), .BL(4)) u_d2 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_cke(cmd_cke),
        .cmd_csbar(cmd_csbar), .cmd_rasbar(cmd_rasbar), .cmd_casbar(cmd_casbar),
        .cmd_webar(cmd_webar), .odt_en(odt_en), .cke_pad(cke_p[2]),
        .csbar_pad(cs_p[2]), .rasbar_pad(ras_p[2]), .casbar_pad(cas_p[2]),
        .webar_pad(we_p[2]), .odt_pad(odt_p[2]), .odt_busy(busy_p[2]),
        .odt_conflict(conf_p[2])
    );

    int on_dly [3] = '{1, 7, 0};
    int hold   [3] = '{5, 7, 5};

    int  cyc;
    bit  m_cke, m_cs, m_ras, m_cas, m_we;
    bit  win [3];
    int  rise [3];
    int  fall [3];
    bit  conf [3];
    bit  exp_odt [3];
    bit  exp_busy [3];

    int compared;
    int mismatched;

    task automatic checkBit(input string tag, input int d, input logic obs, input logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s dut%0d cyc%0d observed=%b expected=%b", tag, d, cyc, obs, expv);
        end
    endtask

    task automatic modelReset();
        m_cke = 1'b0; m_cs = 1'b1; m_ras = 1'b1; m_cas = 1'b1; m_we = 1'b1;
        for (int d = 0; d < 3; d++) begin
            win[d] = 1'b0; conf[d] = 1'b0; exp_odt[d] = 1'b0; exp_busy[d] = 1'b0;
            rise[d] = 0; fall[d] = 0;
        end
    endtask

    // One rising edge: update pad model, then each DUT's ODT window.
    task automatic modelEdge(input bit v, k, cs, ras, cas, we, en);
        bit act, wr, rd, prev;
        if (v) begin
            m_cke = k; m_cs = cs; m_ras = ras; m_cas = cas; m_we = we;
        end else begin
            m_cs = 1'b1; m_ras = 1'b1; m_cas = 1'b1; m_we = 1'b1;
        end
        act = m_cke && !m_cs;
        wr  = act && m_ras && !m_cas && !m_we;
        rd  = act && m_ras && !m_cas && m_we;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            prev = win[d] && ((cyc - 1) < fall[d]);
            if (rd) begin
                if (prev) conf[d] = 1'b1;
                win[d] = 1'b0;
            end else if (!en) begin
                win[d] = 1'b0;
            end else if (wr) begin
                if (!prev) begin
                    win[d]  = 1'b1;
                    rise[d] = cyc + on_dly[d];
                end
                fall[d] = cyc + on_dly[d] + hold[d];
            end
            exp_odt[d]  = win[d] && (cyc >= rise[d]) && (cyc < fall[d]);
            exp_busy[d] = win[d] && (cyc < fall[d]);
        end
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 3; d++) begin
            checkBit("cke_pad", d, cke_p[d], m_cke);
            checkBit("csbar_pad", d, cs_p[d], m_cs);
            checkBit("rasbar_pad", d, ras_p[d], m_ras);
            checkBit("casbar_pad", d, cas_p[d], m_cas);
            checkBit("webar_pad", d, we_p[d], m_we);
            checkBit("odt_pad", d, odt_p[d], exp_odt[d]);
            checkBit("odt_busy", d, busy_p[d], exp_busy[d]);
            checkBit("odt_conflict", d, conf_p[d], conf[d]);
        end
    endtask

    task automatic checkResetValues();
        for (int d = 0; d < 3; d++) begin
            checkBit("rst_cke", d, cke_p[d], 1'b0);
            checkBit("rst_csbar", d, cs_p[d], 1'b1);
            checkBit("rst_rasbar", d, ras_p[d], 1'b1);
            checkBit("rst_casbar", d, cas_p[d], 1'b1);
            checkBit("rst_webar", d, we_p[d], 1'b1);
            checkBit("rst_odt", d, odt_p[d], 1'b0);
            checkBit("rst_busy", d, busy_p[d], 1'b0);
            checkBit("rst_conflict", d, conf_p[d], 1'b0);
        end
    endtask

    // Inputs are driven 1 time unit after an edge, sampled on the next edge,
    // and outputs are checked 1 time unit after that edge.
    task automatic applyStimulus(input bit v, k, cs, ras, cas, we, en);
        cmd_valid = v; cmd_cke = k; cmd_csbar = cs;
        cmd_rasbar = ras; cmd_casbar = cas; cmd_webar = we; odt_en = en;
        @(posedge clk);
        #1;
        modelEdge(v, k, cs, ras, cas, we, en);
        checkOutput();
    endtask

    task automatic doIdle(input int n, input bit en);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, en);
    endtask

    task automatic doWrite(input bit en);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, en);
    endtask

    task automatic doRead(input bit en);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, en);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        modelReset();
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        cyc = 0;
        modelReset();
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_cke = 1'b0; cmd_csbar = 1'b1;
        cmd_rasbar = 1'b1; cmd_casbar = 1'b1; cmd_webar = 1'b1; odt_en = 1'b1;

        #12;
        checkResetValues();
        reset_n = 1'b1;
        $display("[TB] reset released");

        // CKE up, then single WRITE landing on pad cycle 10.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        doIdle(8, 1'b1);
        doWrite(1'b1);
        doIdle(20, 1'b1);

        // Back-to-back writes two cycles apart.
        doWrite(1'b1);
        doIdle(1, 1'b1);
        doWrite(1'b1);
        doIdle(20, 1'b1);

        // Read landing inside a live window sets the sticky conflict.
        doWrite(1'b1);
        doIdle(1, 1'b1);
        doRead(1'b1);
        doIdle(20, 1'b1);

        // Rtt disabled: no window; then Rtt dropped mid-window.
        doWrite(1'b0);
        doIdle(12, 1'b0);
        doWrite(1'b1);
        doIdle(2, 1'b1);
        doIdle(1, 1'b0);
        doIdle(10, 1'b1);

        // Async reset in the middle of a window.
        doWrite(1'b1);
        doIdle(2, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues();
        doReset();
        $display("[TB] mid-window reset done");

        // Random command stream, including reads that may hit windows.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++) begin
            int sel;
            bit en;
            sel = int'($urandom_range(0, 15));
            en  = ($urandom_range(0, 39) != 0);
            if (sel < 4) doWrite(en);
            else if (sel == 4) doRead(en);
            else if (sel < 12) doIdle(1, en);
            else applyStimulus(1'b1, ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                               1'($urandom), 1'($urandom), en);
        end
        doIdle(20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ddr2_odt_ctrl.md
# ddr2_odt_ctrl

Controller-side On-Die-Termination generator for the DDR2 command pad stage. It registers the controller's next command onto the command pads and drives `odt_pad` in lock-step with it. ODT is raised a fixed number of cycles after each WRITE appears on the pads, held through the write burst plus margin, and forced low on any READ. It sits between the controller's command scheduler and the pad ring, and is the producer side of the ODT behaviour checked by the bench's ODT monitor.

## Interface
- `AL`, default 0: additive latency in clocks, legal range 0..4.
- `CL`, default 4: CAS latency in clocks, legal range 3..6.
- `BL`, default 4: burst length, 4 or 8.
- `clk` input, 1 bit: controller clock; all logic is on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `cmd_valid` input, 1 bit: the `cmd_*` fields hold a command to issue next cycle. When low, a deselect is issued.
- `cmd_cke` input, 1 bit: clock enable to present on the pad.
- `cmd_csbar` input, 1 bit: chip select, active low.
- `cmd_rasbar`, `cmd_casbar`, `cmd_webar` input, 1 bit each: command opcode.
- `odt_en` input, 1 bit: Rtt is enabled in EMR. When 0, ODT never asserts.
- `cke_pad`, `csbar_pad`, `rasbar_pad`, `casbar_pad`, `webar_pad` output, 1 bit each: registered command pads.
- `odt_pad` output, 1 bit: registered ODT pad.
- `odt_busy` output, 1 bit: an ODT window is pending or active (state is not IDLE).
- `odt_conflict` output, 1 bit: sticky flag. Set when a READ lands while a window is pending or active.

## Operation
- **Derived constants.**
  - ON_DLY = AL+CL-3, giving 0..7.
  - HOLD = BL/2+3, giving 5 or 7.
  - Counters are 5 bits. Out-of-range parameters fail elaboration with `$fatal`.
- **Pad register.**
  - When `cmd_valid`=1, each pad output takes its `cmd_*` input on the next edge.
  - When `cmd_valid`=0, the pads take deselect: `cke_pad` holds its prior value, `csbar_pad`=1, and ras/cas/we=1.
- **Pad-cycle decode.** These are decoded from the values being loaded into the pads:
  - `act` = cke & !csbar.
  - WRITE = act & ras & !cas & !we.
  - READ = act & ras & !cas & we.
- **FSM states:** IDLE, DELAY, ON. It keeps two counters: `cnt_on` (cycles until ODT rises) and `cnt_off` (cycles until ODT falls).
- **WRITE with `odt_en`=1:**
  - `cnt_off` is loaded with ON_DLY+HOLD.
  - From IDLE: `cnt_on` is loaded with ON_DLY, and the next state is DELAY (or ON when ON_DLY=0).
  - From DELAY: `cnt_on` is unchanged, because the earlier rise time wins.
  - From ON: stay in ON, so ODT stays high continuously through the extended window.
- **DELAY → ON** when `cnt_on` reaches 0.
- **ON → IDLE** when `cnt_off` reaches 0.
- **READ** takes priority over everything:
  - The FSM goes to IDLE and `odt_pad`=0 on the READ pad cycle.
  - If the prior state was not IDLE, `odt_conflict` is set.
  - A simultaneous WRITE cannot occur, because the opcodes are exclusive.
- **`odt_en` falling** mid-window: the FSM goes to IDLE and `odt_pad` falls on the next pad cycle. No conflict is flagged.
- **WRITE with `odt_en`=0:** no window is started.
- **`odt_conflict`** is cleared only by reset.

## Timing
- **Reset values (async assert):**
  - `cke_pad`=0, `csbar_pad`=1, `rasbar_pad`=`casbar_pad`=`webar_pad`=1.
  - `odt_pad`=0, `odt_busy`=0, `odt_conflict`=0.
  - State IDLE, counters 0.
- **Reset release:** synchronous de-assert into IDLE. The first command can be accepted on the first edge after `reset_n` rises.
- **Command latency:** a command sampled at edge N appears on the pads in cycle E=N+1.
- **ODT window:** for a WRITE on the pads at cycle E, `odt_pad`=1 in cycles E+ON_DLY .. E+ON_DLY+HOLD-1, and 0 otherwise (unless the window is extended).
- **READ:** with a READ on the pads at cycle E, `odt_pad`=0 in cycle E, with no exceptions.
- **Back-to-back writes:** a second WRITE at E2 moves the fall to E2+ON_DLY+HOLD. There is no low gap between the windows.
- **`odt_busy`** is high from cycle E through the last ODT-high cycle.
- **Reset mid-window:** the window is dropped immediately and asynchronously.

## Test plan
- **Single write, defaults** (ON_DLY=1, HOLD=5): WRITE on pads at E=10 → `odt_pad` high in cycles 11..15 and low in cycles 10 and 16; `odt_busy` high 10..15.
- **Back-to-back writes:** WRITEs at E=10 and E=12 → `odt_pad` high continuously 11..17 and low at 18.
- **Read conflict:** WRITE at E=10, READ at E=12 → `odt_pad` high at 11 and low from 12 onward; `odt_conflict`=1 and stays 1.
- **Configuration sweep:** AL=4, CL=6, BL=8 (ON_DLY=7, HOLD=7), WRITE at E=20 → high 27..33. Also AL=0, CL=3 (ON_DLY=0): `odt_pad` high in E itself.
- **`odt_en` gating:** with `odt_en`=0, a WRITE gives `odt_pad` always 0 and `odt_busy` 0. Dropping `odt_en` mid-window → `odt_pad` low next cycle, no conflict.
- **Reset behaviour:** assert `reset_n`=0 mid-window → all pads at reset values within the same cycle. A random command stream (`odt_en`=1, reads spaced ≥ ON_DLY+HOLD after writes) → the ODT monitor passes.
